demux1x8: RTL and testbench
===========================

DEMUX1X8 -- requirements
Module: demux1x8

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, both named as the codebase names them.
REQ-002 SHALL expose the ports below, listed as name, direction, width, meaning.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  1  data bit to route.
- sel  input  3  destination channel index, 0..7.
- in_valid  input  1  din/sel valid.
- in_ready  output  1  block can accept this cycle.
- d0..d7  output  1 each  routed data; dK is driven only for the held channel.
- out_valid  output  8  bit K = dK valid.
- out_ready  input  8  bit K = channel K sink ready.
- xfer_cnt  output  16  completed output transfers (present only with DEMUX_CNT_EN).
REQ-003 SHALL take no parameters; widths are fixed as listed.

Function
REQ-004 SHALL hold a single-entry register: full flag, held_din, held_sel[2:0].
REQ-005 SHALL have two states, EMPTY (full=0) and FULL (full=1).
REQ-006 SHALL define accept = in_valid & in_ready.
REQ-007 SHALL define release = full & out_ready[held_sel].
REQ-008 SHALL drive in_ready = ~full | out_ready[held_sel], combinationally.
REQ-009 On accept, SHALL capture din->held_din and sel->held_sel at that edge.
REQ-010 EMPTY->FULL on accept.
REQ-011 FULL->EMPTY on release without accept.
REQ-012 On release and accept in the same cycle, SHALL stay FULL and load the new entry (zero-bubble pass-through).
REQ-013 SHALL keep held_din and held_sel stable while FULL and not released.
REQ-014 out_valid SHALL be one-hot or zero: out_valid[held_sel]=full, all other bits 0.
REQ-015 dK SHALL equal held_din when full and K==held_sel, else 0.
REQ-016 Latency SHALL be exactly 1 cycle from accept to the corresponding out_valid.
REQ-017 out_ready bits of non-selected channels SHALL have no effect.
REQ-018 in_valid while FULL and not released SHALL be ignored; upstream holds per valid/ready rules.
REQ-019 Routing SHALL be in order: entries leave in the order accepted, with no loss or duplication.

Reset
REQ-020 While rst=1 at a clock edge: full=0, held_din=0, held_sel=0, xfer_cnt=0.
REQ-021 While rst=1: out_valid=0, all dK=0.
REQ-022 While rst=1: in_ready=0, so any in_valid in that cycle is dropped.
REQ-023 Reset asserted mid-transfer SHALL discard the held entry without producing a release.

Configuration
REQ-024 SHALL use macro DEMUX_CNT_EN.
REQ-025 With DEMUX_CNT_EN defined, SHALL present xfer_cnt, incremented by 1 on each release and wrapping from 0xFFFF to 0x0000.
REQ-026 Without DEMUX_CNT_EN, the xfer_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Bench SHALL cover reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=8'h00, d0..d7=0, in_ready=0, xfer_cnt=0.
REQ-028 Bench SHALL cover basic routing: din=1, sel=5, in_valid=1, out_ready=8'hFF for 1 cycle -> next cycle out_valid=8'h20, d5=1, others 0; xfer_cnt=1 after the release edge.
REQ-029 Bench SHALL cover backpressure: hold sel=3, out_ready=8'h00 for 4 cycles -> out_valid=8'h08 stable, in_ready=0, a second in_valid is ignored; raise out_ready[3] -> release in 1 cycle.
REQ-030 Bench SHALL cover non-selected ready: FULL with held_sel=2, out_ready=8'hFB -> no release, in_ready=0.
REQ-031 Bench SHALL cover streaming: sels 0,1,...,7 back-to-back with din alternating 1,0, all ready -> out_valid walks 01,02,...,80 on consecutive cycles, data matches, xfer_cnt=8.
REQ-032 Bench SHALL cover wrap and mid-operation reset: preload xfer_cnt to 0xFFFF then 1 release -> 0x0000; rst while FULL -> out_valid=0 next cycle, count not incremented.

Source files
------------

// File: rtl/demux1x8_if.sv
// rtl/demux1x8_if.sv - single-bit 1-to-8 demux bus: upstream din/sel handshake plus eight routed outputs
//   din        upstream data bit to route
//   sel[2:0]   destination channel index 0..7
//   in_valid   din/sel valid
//   in_ready   demux can accept this cycle
//   d0..d7     routed data, only the held channel is ever non-zero
//   out_valid  bit K = dK valid (one-hot or zero)
//   out_ready  bit K = channel K sink ready
//   master modport: upstream source and downstream sinks; slave modport: the demux itself
interface demux1x8_if;
  logic       din;
  logic [2:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic       d0;
  logic       d1;
  logic       d2;
  logic       d3;
  logic       d4;
  logic       d5;
  logic       d6;
  logic       d7;
  logic [7:0] out_valid;
  logic [7:0] out_ready;

  modport master (
    output din, sel, in_valid, out_ready,
    input  in_ready, d0, d1, d2, d3, d4, d5, d6, d7, out_valid
  );

  modport slave (
    input  din, sel, in_valid, out_ready,
    output in_ready, d0, d1, d2, d3, d4, d5, d6, d7, out_valid
  );
endinterface

// File: rtl/demux1x8.sv
// rtl/demux1x8.sv - single-entry registered 1-to-8 demultiplexer with valid/ready on both sides
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       demux1x8_if.slave: din, sel, in_valid, in_ready, d0..d7, out_valid, out_ready
//   xfer_cnt  16-bit wrapping count of completed output transfers (only with DEMUX_CNT_EN)
// Optional feature macro: DEMUX_CNT_EN
module demux1x8 (
  input  logic         clk,
  input  logic         rst,
  demux1x8_if.slave    bus
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]  xfer_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       held_din;
  logic [2:0] held_sel;
  logic       full;
  logic       sel_ready;
  logic       accept;
  logic       release_now;
  logic [7:0] hot;
  logic [7:0] dvec;

  assign full      = (state_q == FULL);
  assign sel_ready = bus.out_ready[held_sel];

  // Ready is forced low during reset so anything offered in that cycle is dropped.
  assign bus.in_ready = ~rst & (~full | sel_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  // Reset wins over a release: a held entry discarded by reset is never counted.
  assign release_now  = ~rst & full & sel_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (release_now && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A simultaneous release and accept reloads the register, giving zero-bubble streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_din <= 1'b0;
      held_sel <= 3'd0;
    end else if (accept) begin
      held_din <= bus.din;
      held_sel <= bus.sel;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= 16'h0000;
    end else if (release_now) begin
      xfer_cnt <= xfer_cnt + 16'h0001;
    end
  end
`endif

  // Outputs are gated by rst so the bus is quiet for the whole reset cycle.
  assign hot  = (~rst & full) ? (8'b0000_0001 << held_sel) : 8'h00;
  assign dvec = held_din ? hot : 8'h00;

  assign bus.out_valid = hot;
  assign bus.d0 = dvec[0];
  assign bus.d1 = dvec[1];
  assign bus.d2 = dvec[2];
  assign bus.d3 = dvec[3];
  assign bus.d4 = dvec[4];
  assign bus.d5 = dvec[5];
  assign bus.d6 = dvec[6];
  assign bus.d7 = dvec[7];

endmodule

// File: tb/tb_demux1x8.sv
// tb/tb_demux1x8.sv - directed table-driven bench for demux1x8
module tb_demux1x8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux1x8_if bus ();

`ifdef DEMUX_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  demux1x8 dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DEMUX_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        din;
    logic [2:0]  sel;
    logic        iv;
    logic [7:0]  ordy;
    logic [7:0]  ov;
    logic [7:0]  d;
    logic        ir;
    logic        chk_cnt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic di, input logic [2:0] s, input logic iv,
                     input logic [7:0] ordy, input logic [7:0] ov, input logic [7:0] d,
                     input logic ir, input logic cc, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.din = di; v.sel = s; v.iv = iv; v.ordy = ordy;
    v.ov = ov; v.d = d; v.ir = ir; v.chk_cnt = cc; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dbus();
    return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  task automatic drive(input logic r, input logic di, input logic [2:0] s,
                       input logic iv, input logic [7:0] ordy);
    rst = r; bus.din = di; bus.sel = s; bus.in_valid = iv; bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] exp);
`ifdef DEMUX_CNT_EN
    chk(name, {16'h0, xfer_cnt}, {16'h0, exp});
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //   rst din sel iv ordy   ov     d      ir cc cnt
    add(1, 1, 5, 1, 8'hFF, 8'h00, 8'h00, 0, 0, 0);   // reset, offer ignored
    add(1, 1, 5, 1, 8'hFF, 8'h00, 8'h00, 0, 1, 0);
    add(0, 1, 5, 1, 8'hFF, 8'h00, 8'h00, 1, 1, 0);   // basic routing: accept din=1 sel=5
    add(0, 0, 0, 0, 8'hFF, 8'h20, 8'h20, 1, 1, 0);   // d5 valid, released
    add(0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 1);
    add(0, 1, 3, 1, 8'h00, 8'h00, 8'h00, 1, 1, 1);   // backpressure: accept sel=3
    add(0, 0, 6, 1, 8'h00, 8'h08, 8'h08, 0, 1, 1);   // second offer ignored while stalled
    add(0, 0, 6, 1, 8'h00, 8'h08, 8'h08, 0, 1, 1);
    add(0, 0, 6, 1, 8'h00, 8'h08, 8'h08, 0, 1, 1);
    add(0, 0, 6, 1, 8'h00, 8'h08, 8'h08, 0, 1, 1);
    add(0, 0, 0, 0, 8'h08, 8'h08, 8'h08, 1, 1, 1);   // out_ready[3] releases
    add(0, 0, 0, 0, 8'h08, 8'h00, 8'h00, 1, 1, 2);
    add(0, 0, 2, 1, 8'h00, 8'h00, 8'h00, 1, 1, 2);   // non-selected ready: accept sel=2 din=0
    add(0, 1, 7, 1, 8'hFB, 8'h04, 8'h00, 0, 1, 2);   // every ready but ch2: held
    add(0, 1, 7, 1, 8'hFB, 8'h04, 8'h00, 0, 1, 2);
    add(0, 0, 0, 0, 8'h04, 8'h04, 8'h00, 1, 1, 2);
    add(0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 3);
    add(0, 1, 0, 1, 8'hFF, 8'h00, 8'h00, 1, 1, 3);   // streaming sels 0..7
    add(0, 0, 1, 1, 8'hFF, 8'h01, 8'h01, 1, 1, 3);
    add(0, 1, 2, 1, 8'hFF, 8'h02, 8'h00, 1, 1, 4);
    add(0, 0, 3, 1, 8'hFF, 8'h04, 8'h04, 1, 1, 5);
    add(0, 1, 4, 1, 8'hFF, 8'h08, 8'h00, 1, 1, 6);
    add(0, 0, 5, 1, 8'hFF, 8'h10, 8'h10, 1, 1, 7);
    add(0, 1, 6, 1, 8'hFF, 8'h20, 8'h00, 1, 1, 8);
    add(0, 0, 7, 1, 8'hFF, 8'h40, 8'h40, 1, 1, 9);
    add(0, 0, 0, 0, 8'hFF, 8'h80, 8'h00, 1, 1, 10);
    add(0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 11);  // eight streamed releases done

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].din, vq[i].sel, vq[i].iv, vq[i].ordy);
      #1;
      chk($sformatf("row%0d_out_valid", i), {24'h0, bus.out_valid}, {24'h0, vq[i].ov});
      chk($sformatf("row%0d_d", i), {24'h0, dbus()}, {24'h0, vq[i].d});
      chk($sformatf("row%0d_in_ready", i), {31'h0, bus.in_ready}, {31'h0, vq[i].ir});
      if (vq[i].chk_cnt) chk_cnt($sformatf("row%0d_xfer_cnt", i), vq[i].cnt);
      tick();
    end

`ifdef DEMUX_CNT_EN
    // Counter wrap: 11 releases so far, 65524 more brings it to 0xFFFF.
    drive(0, 0, 0, 1, 8'hFF);
    for (int i = 0; i < 65524; i++) tick();
    drive(0, 0, 0, 0, 8'hFF);
    tick();
    chk_cnt("cnt_ffff", 16'hFFFF);
    drive(0, 1, 0, 1, 8'hFF);
    tick();
    drive(0, 0, 0, 0, 8'hFF);
    #1;
    chk("wrap_out_valid", {24'h0, bus.out_valid}, 32'h01);
    tick();
    chk_cnt("cnt_wrap", 16'h0000);
`endif

    // Reset while FULL discards the held entry.
    drive(0, 1, 1, 1, 8'h00);
    #1;
    chk("mid_accept_ready", {31'h0, bus.in_ready}, 32'h1);
    tick();
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("mid_full_out_valid", {24'h0, bus.out_valid}, 32'h02);
    chk("mid_full_d", {24'h0, dbus()}, 32'h02);
    tick();
    drive(1, 1, 4, 1, 8'hFF);
    #1;
    chk("mid_rst_out_valid", {24'h0, bus.out_valid}, 32'h00);
    chk("mid_rst_d", {24'h0, dbus()}, 32'h00);
    chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("post_rst_out_valid", {24'h0, bus.out_valid}, 32'h00);
    chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk_cnt("post_rst_cnt", 16'h0000);
    tick();
    drive(0, 0, 0, 0, 8'hFF);
    #1;
    chk("post_rst_idle_out_valid", {24'h0, bus.out_valid}, 32'h00);
    chk_cnt("post_rst_no_release", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
